// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz pixel timing generator.
// Produces the scan coordinates DrawX/DrawY and the active-video flag blank
// with zero latency. It also produces line_start/frame_start strobes, and
// active-low hs/vs that are delayed SYNC_DELAY clocks so they line up with
// registered RGB.
// A single IDLE cycle after reset holds the counters at (0,0). After that the
// block free-runs in RUN until the next reset.
// Parameter limits: each total must fit the 10-bit counters (<= 1024), and
// SYNC_DELAY must be in the range 0..4.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 2
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic       line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       run;
    logic       hs_raw;
    logic       vs_raw;

    // Next-state and counter advance: IDLE only arms RUN; RUN scans the frame.
    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        vc_d    = vc_q;
        unique case (state_q)
            IDLE: begin
                state_d = RUN;
            end
            RUN: begin
                if (hc_q == H_LAST) begin
                    hc_d = 10'd0;
                    vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
                end else begin
                    hc_d = hc_q + 10'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers, asynchronously cleared.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hc_q    <= 10'd0;
            vc_q    <= 10'd0;
        end else begin
            state_q <= state_d;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
        end
    end

    // Zero-latency decodes from the counters, gated off while idle.
    always_comb begin
        run         = (state_q == RUN);
        blank       = run && (hc_q < H_VIS) && (vc_q < V_VIS);
        line_start  = run && (hc_q == 10'd0);
        frame_start = run && (hc_q == 10'd0) && (vc_q == 10'd0);
        hs_raw      = !(run && (hc_q >= HS_START) && (hc_q < HS_END));
        vs_raw      = !(run && (vc_q >= VS_START) && (vc_q < VS_END));
    end

    assign DrawX = hc_q;
    assign DrawY = vc_q;

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign hs = hs_raw;
            assign vs = vs_raw;
        end else begin : g_delay
            logic [SYNC_DELAY-1:0] hs_pipe_q, hs_pipe_d;
            logic [SYNC_DELAY-1:0] vs_pipe_q, vs_pipe_d;

            // Shift the raw syncs one stage per clock.
            always_comb begin
                hs_pipe_d    = hs_pipe_q;
                vs_pipe_d    = vs_pipe_q;
                hs_pipe_d[0] = hs_raw;
                vs_pipe_d[0] = vs_raw;
                for (int i = 1; i < SYNC_DELAY; i++) begin
                    hs_pipe_d[i] = hs_pipe_q[i-1];
                    vs_pipe_d[i] = vs_pipe_q[i-1];
                end
            end

            // Pipeline stages reset to the inactive level, so no partial
            // pulse survives a reset.
            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    hs_pipe_q <= '1;
                    vs_pipe_q <= '1;
                end else begin
                    hs_pipe_q <= hs_pipe_d;
                    vs_pipe_q <= vs_pipe_d;
                end
            end

            assign hs = hs_pipe_q[SYNC_DELAY-1];
            assign vs = vs_pipe_q[SYNC_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen.
// dut_a uses the full 640x480 timing with SYNC_DELAY=2. dut_b shrinks the
// vertical timing to 30 lines (20/3/2/5) so that whole frames fit in a short
// run. dut_c is dut_b built with SYNC_DELAY=0.
// Expected values come from the cycle index n since the first RUN cycle:
// x = n % 800 and y = (n / 800) % V_TOTAL. Each sync equals its raw decode
// taken SYNC_DELAY cycles earlier, and is high before RUN.
module tb_vga_timing_gen;

    localparam int H_TOT   = 800;
    localparam int H_VIS   = 640;
    localparam int HS0     = 656;
    localparam int HS1     = 752;
    localparam int VT_A    = 525;
    localparam int VV_A    = 480;
    localparam int VS0_A   = 490;
    localparam int VT_B    = 30;
    localparam int VV_B    = 20;
    localparam int VS0_B   = 23;
    localparam int FRAME_B = H_TOT * VT_B;

    logic       vga_clk;
    logic       reset_n;
    logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
    logic       a_blank, a_hs, a_vs, a_fs, a_ls;
    logic       b_blank, b_hs, b_vs, b_fs, b_ls;
    logic       c_blank, c_hs, c_vs, c_fs, c_ls;

    int checks   = 0;
    int failures = 0;
    int cur_n    = -1;

    int hs_low_line0, first_hs_low_x;
    int vs_low_b, first_vs_low_b;
    int vs_low_c, first_vs_low_c;
    int ls_cnt_a, last_fs_b;

    vga_timing_gen dut_a (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(a_x), .DrawY(a_y),
        .blank(a_blank), .hs(a_hs), .vs(a_vs),
        .frame_start(a_fs), .line_start(a_ls)
    );

    vga_timing_gen #(.V_ACTIVE(20), .V_FP(3), .V_SYNC(2), .V_BP(5)) dut_b (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(b_x), .DrawY(b_y),
        .blank(b_blank), .hs(b_hs), .vs(b_vs),
        .frame_start(b_fs), .line_start(b_ls)
    );

    vga_timing_gen #(.V_ACTIVE(20), .V_FP(3), .V_SYNC(2), .V_BP(5),
                     .SYNC_DELAY(0)) dut_c (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(c_x), .DrawY(c_y),
        .blank(c_blank), .hs(c_hs), .vs(c_vs),
        .frame_start(c_fs), .line_start(c_ls)
    );

    // 25 MHz pixel clock
    initial begin
        vga_clk = 1'b0;
        forever #20 vga_clk = ~vga_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s n=%0d observed=%0d expected=%0d",
                     tag, cur_n, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic int hraw(input int m);
        if (m < 0) return 1;
        return ((m % H_TOT) >= HS0 && (m % H_TOT) < HS1) ? 0 : 1;
    endfunction

    function automatic int vraw(input int m, input int vt, input int vs0);
        int y;
        if (m < 0) return 1;
        y = (m / H_TOT) % vt;
        return (y >= vs0 && y < vs0 + 2) ? 0 : 1;
    endfunction

    task automatic check_cycle(input int n);
        int x, ya, yb;
        cur_n = n;
        x  = n % H_TOT;
        ya = (n / H_TOT) % VT_A;
        yb = (n / H_TOT) % VT_B;
        chk("a_x", 32'(a_x), x);
        chk("a_y", 32'(a_y), ya);
        chk("a_blank", 32'(a_blank), (x < H_VIS && ya < VV_A) ? 1 : 0);
        chk("a_hs", 32'(a_hs), hraw(n - 2));
        chk("a_vs", 32'(a_vs), vraw(n - 2, VT_A, VS0_A));
        chk("a_fs", 32'(a_fs), (x == 0 && ya == 0) ? 1 : 0);
        chk("a_ls", 32'(a_ls), (x == 0) ? 1 : 0);
        chk("b_x", 32'(b_x), x);
        chk("b_y", 32'(b_y), yb);
        chk("b_blank", 32'(b_blank), (x < H_VIS && yb < VV_B) ? 1 : 0);
        chk("b_hs", 32'(b_hs), hraw(n - 2));
        chk("b_vs", 32'(b_vs), vraw(n - 2, VT_B, VS0_B));
        chk("b_fs", 32'(b_fs), (x == 0 && yb == 0) ? 1 : 0);
        chk("b_ls", 32'(b_ls), (x == 0) ? 1 : 0);
        chk("c_x", 32'(c_x), x);
        chk("c_y", 32'(c_y), yb);
        chk("c_blank", 32'(c_blank), (x < H_VIS && yb < VV_B) ? 1 : 0);
        chk("c_hs", 32'(c_hs), hraw(n));
        chk("c_vs", 32'(c_vs), vraw(n, VT_B, VS0_B));
        chk("c_fs", 32'(c_fs), (x == 0 && yb == 0) ? 1 : 0);
        chk("c_ls", 32'(c_ls), (x == 0) ? 1 : 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_a_x"}, 32'(a_x), 0);
        chk({tag, "_a_y"}, 32'(a_y), 0);
        chk({tag, "_a_blank"}, 32'(a_blank), 0);
        chk({tag, "_a_hs"}, 32'(a_hs), 1);
        chk({tag, "_a_vs"}, 32'(a_vs), 1);
        chk({tag, "_a_fs"}, 32'(a_fs), 0);
        chk({tag, "_a_ls"}, 32'(a_ls), 0);
        chk({tag, "_b_vs"}, 32'(b_vs), 1);
        chk({tag, "_b_hs"}, 32'(b_hs), 1);
        chk({tag, "_c_hs"}, 32'(c_hs), 1);
        chk({tag, "_c_vs"}, 32'(c_vs), 1);
    endtask

    // Checks cycles n = first .. first+count-1, gathering pulse statistics.
    task automatic run_cycles(input int first, input int count);
        for (int n = first; n < first + count; n++) begin
            check_cycle(n);
            if (n < H_TOT && a_hs == 1'b0) begin
                if (hs_low_line0 == 0) first_hs_low_x = n;
                hs_low_line0++;
            end
            if (n < FRAME_B && b_vs == 1'b0) begin
                if (vs_low_b == 0) first_vs_low_b = n;
                vs_low_b++;
            end
            if (n < FRAME_B && c_vs == 1'b0) begin
                if (vs_low_c == 0) first_vs_low_c = n;
                vs_low_c++;
            end
            if (n < FRAME_B && a_ls == 1'b1) ls_cnt_a++;
            if (b_fs == 1'b1 && n > 0) begin
                chk("b_frame_period", n - last_fs_b, FRAME_B);
                last_fs_b = n;
            end
            if (n == 4799) begin
                chk("wrap_799_5_x", 32'(a_x), 799);
                chk("wrap_799_5_y", 32'(a_y), 5);
            end
            if (n == 4800) begin
                chk("wrap_0_6_x", 32'(a_x), 0);
                chk("wrap_0_6_y", 32'(a_y), 6);
            end
            if (n == FRAME_B - 1) begin
                chk("b_last_x", 32'(b_x), 799);
                chk("b_last_y", 32'(b_y), VT_B - 1);
            end
            if (n == FRAME_B) begin
                chk("b_frame_wrap_y", 32'(b_y), 0);
                chk("b_frame_wrap_fs", 32'(b_fs), 1);
            end
            @(negedge vga_clk);
        end
    endtask

    // Directed sequence: reset, three short frames, mid-frame reset, restart.
    initial begin
        hs_low_line0 = 0; first_hs_low_x = -1;
        vs_low_b = 0; first_vs_low_b = -1;
        vs_low_c = 0; first_vs_low_c = -1;
        ls_cnt_a = 0; last_fs_b = 0;

        reset_n = 1'b0;
        repeat (5) @(negedge vga_clk);
        check_reset_values("in_reset");

        reset_n = 1'b1;
        #1;
        check_reset_values("idle");
        @(negedge vga_clk);

        cur_n = 0;
        chk("first_x", 32'(a_x), 0);
        chk("first_blank", 32'(a_blank), 1);
        chk("first_fs", 32'(a_fs), 1);
        chk("first_ls", 32'(a_ls), 1);

        run_cycles(0, 67100);

        chk("hs_low_count_line0", hs_low_line0, 96);
        chk("hs_first_low_x", first_hs_low_x, 658);
        chk("b_vs_low_count", vs_low_b, 1600);
        chk("b_vs_first_low_n", first_vs_low_b, VS0_B * H_TOT + 2);
        chk("c_vs_low_count", vs_low_c, 1600);
        chk("c_vs_first_low_n", first_vs_low_c, VS0_B * H_TOT);
        chk("a_line_start_count", ls_cnt_a, VT_B);
        chk("b_last_fs_n", last_fs_b, 2 * FRAME_B);

        // n = 67100: x = 700 (hsync low), dut_b on line 23 (vsync low)
        check_cycle(67100);
        chk("pre_rst_a_hs", 32'(a_hs), 0);
        chk("pre_rst_b_vs", 32'(b_vs), 0);
        chk("pre_rst_a_x", 32'(a_x), 700);
        #2;
        reset_n = 1'b0;
        #1;
        cur_n = -1;
        check_reset_values("async_rst");
        chk("async_rst_b_blank", 32'(b_blank), 0);
        repeat (3) @(negedge vga_clk);
        check_reset_values("held_rst");

        reset_n = 1'b1;
        #1;
        check_reset_values("idle2");
        @(negedge vga_clk);

        cur_n = 0;
        chk("restart_fs", 32'(a_fs), 1);
        chk("restart_blank", 32'(a_blank), 1);
        run_cycles(0, 2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
